// File: rtl/vt52_term_core.sv
// VT52-style terminal engine: 7-bit char stream in, screen RAM writes and ESC Z replies out; writes land 1 cycle after transfer.
// in_ready is held low while a clear walks the RAM (one cell per cycle) or while the identify reply is being handshaked.
module vt52_term_core #(
    parameter int COLS     = 80,
    parameter int ROWS     = 24,
    parameter int CW       = 7,
    parameter int RW       = 5,
    parameter int TABW     = 8,
    parameter int AUTOWRAP = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [6:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [CW-1:0] mem_col,
    output logic [RW-1:0] mem_row,
    output logic [6:0]    mem_wdata,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic [RW-1:0] topline,
    output logic          bell,
    output logic [6:0]    rep_data,
    output logic          rep_valid,
    input  logic          rep_ready
);
    typedef enum logic [2:0] {S_IDLE, S_ESC, S_CADY, S_CADX, S_CLEAR, S_REPLY} state_t;

    localparam int            NCELL = ROWS * COLS;
    localparam int            NW    = $clog2(NCELL + 1);
    localparam logic [CW-1:0] LASTC = CW'(COLS - 1);
    localparam logic [RW-1:0] LASTR = RW'(ROWS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, clr_col_q, clr_col_d, wcol_q, wcol_d;
    logic [RW-1:0]   lrow_q, lrow_d, crow_q, crow_d, top_q, top_d;
    logic [RW-1:0]   clr_row_q, clr_row_d, wrow_q, wrow_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [6:0]      wdat_q, wdat_d, rep_dat_q, rep_dat_d;
    logic [1:0]      rep_idx_q, rep_idx_d;
    logic            we_q, we_d, bell_q, bell_d, rep_vld_q, rep_vld_d;

    logic            st_go;
    logic [CW-1:0]   st_col;
    logic [RW-1:0]   st_row;
    logic [NW-1:0]   st_n;

    logic            fire, is_print, at_bot, at_top, at_endc, lf_scroll, wrap_scroll;
    logic [RW-1:0]   top_inc, top_dec;
    logic [CW:0]     tab_nt;
    logic [6:0]      cad_v;

    function automatic logic [CW+RW-1:0] step_cell(input logic [CW-1:0] c, input logic [RW-1:0] r);
        if (c != LASTC)
            return {c + CW'(1), r};
        return {CW'(0), (r == LASTR) ? RW'(0) : r + RW'(1)};
    endfunction

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] l, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, l} + {1'b0, t};
        if (s >= (RW+1)'(ROWS))
            s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_ESC) || (state_q == S_CADY) || (state_q == S_CADX);
    assign fire        = in_valid && in_ready;
    assign is_print    = (in_data >= 7'h20) && (in_data != 7'h7F);
    assign at_bot      = (lrow_q == LASTR);
    assign at_top      = (lrow_q == '0);
    assign at_endc     = (col_q == LASTC);
    assign lf_scroll   = (in_data == 7'h0A) && at_bot;
    assign wrap_scroll = is_print && at_endc && (AUTOWRAP != 0) && at_bot;
    assign top_inc     = (top_q == LASTR) ? '0 : top_q + RW'(1);
    assign top_dec     = (top_q == '0) ? LASTR : top_q - RW'(1);
    assign tab_nt      = ({1'b0, col_q} | (CW+1)'(TABW - 1)) + (CW+1)'(1);
    assign cad_v       = in_data - 7'h20;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            cnt_q     <= NW'(NCELL);
            col_q     <= '0;
            lrow_q    <= '0;
            crow_q    <= '0;
            top_q     <= '0;
            clr_col_q <= '0;
            clr_row_q <= '0;
            we_q      <= 1'b0;
            wcol_q    <= '0;
            wrow_q    <= '0;
            wdat_q    <= '0;
            bell_q    <= 1'b0;
            rep_vld_q <= 1'b0;
            rep_dat_q <= '0;
            rep_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            lrow_q    <= lrow_d;
            crow_q    <= crow_d;
            top_q     <= top_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            we_q      <= we_d;
            wcol_q    <= wcol_d;
            wrow_q    <= wrow_d;
            wdat_q    <= wdat_d;
            bell_q    <= bell_d;
            rep_vld_q <= rep_vld_d;
            rep_dat_q <= rep_dat_d;
            rep_idx_q <= rep_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fire) begin
                         if (in_data == 7'h1B)              state_d = S_ESC;
                         else if (lf_scroll || wrap_scroll) state_d = S_CLEAR;
                     end
            S_ESC:   if (fire) begin
                         case (in_data)
                             7'h49:        state_d = at_top ? S_CLEAR : S_IDLE;
                             7'h4A, 7'h4B: state_d = S_CLEAR;
                             7'h59:        state_d = S_CADY;
                             7'h5A:        state_d = S_REPLY;
                             default:      state_d = S_IDLE;
                         endcase
                     end
            S_CADY:  if (fire) state_d = S_CADX;
            S_CADX:  if (fire) state_d = S_IDLE;
            S_CLEAR: if (cnt_q == '0) state_d = S_IDLE;
            S_REPLY: if (rep_ready && rep_idx_q == 2'd2) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_d     = col_q;
        lrow_d    = lrow_q;
        top_d     = top_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        wcol_d    = wcol_q;
        wrow_d    = wrow_q;
        wdat_d    = wdat_q;
        bell_d    = 1'b0;
        rep_vld_d = rep_vld_q;
        rep_dat_d = rep_dat_q;
        rep_idx_d = rep_idx_q;
        st_go     = 1'b0;
        st_col    = '0;
        st_row    = '0;
        st_n      = '0;
        case (state_q)
            S_IDLE: if (fire) begin
                if (is_print) begin
                    we_d   = 1'b1;
                    wcol_d = col_q;
                    wrow_d = crow_q;
                    wdat_d = in_data;
                    if (!at_endc) begin
                        col_d = col_q + CW'(1);
                    end else if (AUTOWRAP != 0) begin
                        col_d = '0;
                        if (!at_bot) begin
                            lrow_d = lrow_q + RW'(1);
                        end else begin
                            // RAM port is busy with the character, so the row clear starts next cycle
                            top_d     = top_inc;
                            clr_col_d = '0;
                            clr_row_d = top_q;
                            cnt_d     = NW'(COLS);
                        end
                    end
                end else begin
                    case (in_data)
                        7'h07: bell_d = 1'b1;
                        7'h08: if (col_q != '0) col_d = col_q - CW'(1);
                        7'h09: begin
                            if (tab_nt <= (CW+1)'(COLS - 1)) col_d = tab_nt[CW-1:0];
                            else if (!at_endc)                col_d = col_q + CW'(1);
                        end
                        7'h0A: begin
                            if (!at_bot) begin
                                lrow_d = lrow_q + RW'(1);
                            end else begin
                                top_d  = top_inc;
                                st_go  = 1'b1;
                                st_row = top_q;
                                st_n   = NW'(COLS);
                            end
                        end
                        7'h0D: col_d = '0;
                        default: ;
                    endcase
                end
            end
            S_ESC: if (fire) begin
                case (in_data)
                    7'h41: if (!at_top)   lrow_d = lrow_q - RW'(1);
                    7'h42: if (!at_bot)   lrow_d = lrow_q + RW'(1);
                    7'h43: if (!at_endc)  col_d  = col_q + CW'(1);
                    7'h44: if (col_q != '0) col_d = col_q - CW'(1);
                    7'h48: begin
                        col_d  = '0;
                        lrow_d = '0;
                    end
                    7'h49: begin
                        if (at_top) begin
                            top_d  = top_dec;
                            st_go  = 1'b1;
                            st_row = top_dec;
                            st_n   = NW'(COLS);
                        end else begin
                            lrow_d = lrow_q - RW'(1);
                        end
                    end
                    7'h4A: begin
                        st_go  = 1'b1;
                        st_col = col_q;
                        st_row = crow_q;
                        st_n   = NW'((ROWS - 1 - int'(lrow_q)) * COLS + COLS - int'(col_q));
                    end
                    7'h4B: begin
                        st_go  = 1'b1;
                        st_col = col_q;
                        st_row = crow_q;
                        st_n   = NW'(COLS - int'(col_q));
                    end
                    7'h5A: begin
                        rep_vld_d = 1'b1;
                        rep_dat_d = 7'h1B;
                        rep_idx_d = 2'd0;
                    end
                    default: ;
                endcase
            end
            S_CADY: if (fire && in_data >= 7'h20 && int'(cad_v) < ROWS) lrow_d = RW'(cad_v);
            S_CADX: if (fire && in_data >= 7'h20) col_d = (int'(cad_v) >= COLS - 1) ? LASTC : CW'(cad_v);
            S_CLEAR: if (cnt_q != '0) begin
                we_d                   = 1'b1;
                wcol_d                 = clr_col_q;
                wrow_d                 = clr_row_q;
                wdat_d                 = 7'h00;
                {clr_col_d, clr_row_d} = step_cell(clr_col_q, clr_row_q);
                cnt_d                  = cnt_q - NW'(1);
            end
            S_REPLY: if (rep_ready) begin
                case (rep_idx_q)
                    2'd0:    begin rep_dat_d = 7'h2F; rep_idx_d = 2'd1; end
                    2'd1:    begin rep_dat_d = 7'h4B; rep_idx_d = 2'd2; end
                    default: begin rep_vld_d = 1'b0;  rep_idx_d = 2'd0; end
                endcase
            end
            default: ;
        endcase
        // First clear cell goes out with the transfer edge; the walker holds the remainder
        if (st_go) begin
            we_d                   = 1'b1;
            wcol_d                 = st_col;
            wrow_d                 = st_row;
            wdat_d                 = 7'h00;
            {clr_col_d, clr_row_d} = step_cell(st_col, st_row);
            cnt_d                  = st_n - NW'(1);
        end
    end

    assign crow_d    = phys_row(lrow_d, top_d);
    assign mem_we    = we_q;
    assign mem_col   = wcol_q;
    assign mem_row   = wrow_q;
    assign mem_wdata = wdat_q;
    assign cur_col   = col_q;
    assign cur_row   = crow_q;
    assign topline   = top_q;
    assign bell      = bell_q;
    assign rep_data  = rep_dat_q;
    assign rep_valid = rep_vld_q;
endmodule

// File: tb/tb_vt52_term_core.sv
// Bench for vt52_term_core: a screen/cursor reference model queues expected RAM writes and reply bytes; monitors pop and compare.
module tb_vt52_term_core;
    localparam int COLS = 80, ROWS = 24, CW = 7, RW = 5, TABW = 8, AW = 1;

    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] in_data = '0;
    logic in_valid = 1'b0, rep_ready = 1'b0;
    logic in_ready, mem_we, bell, rep_valid;
    logic [CW-1:0] mem_col, cur_col;
    logic [RW-1:0] mem_row, cur_row, topline;
    logic [6:0] mem_wdata, rep_data;

    vt52_term_core #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .TABW(TABW), .AUTOWRAP(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_col(mem_col), .mem_row(mem_row), .mem_wdata(mem_wdata),
        .cur_col(cur_col), .cur_row(cur_row), .topline(topline), .bell(bell),
        .rep_data(rep_data), .rep_valid(rep_valid), .rep_ready(rep_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int col; int row; int dat;} wr_t;
    wr_t wq[$];
    int  rq[$];
    int  errors = 0, checks = 0;
    int  m_col = 0, m_lrow = 0, m_top = 0, m_mode = 0;
    int  exp_bells = 0, seen_bells = 0;
    bit  exp_bell;
    int  cyc = 0, stall_until = 0;
    bit  rp_pend = 0;
    int  rp_dat = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int phys();
        return (m_lrow + m_top) % ROWS;
    endfunction

    task automatic push_clear(input int c, input int r, input int n);
        for (int k = 0; k < n; k++) begin
            wq.push_back('{col: c, row: r, dat: 0});
            c++;
            if (c == COLS) begin
                c = 0;
                r = (r + 1) % ROWS;
            end
        end
    endtask

    task automatic line_feed();
        if (m_lrow < ROWS - 1) begin
            m_lrow++;
        end else begin
            m_top = (m_top + 1) % ROWS;
            push_clear(0, phys(), COLS);
        end
    endtask

    // Screen-level model: what the terminal should do with one accepted character
    task automatic model_step(input int c);
        int nt;
        exp_bell = 0;
        case (m_mode)
            0: begin
                if (c >= 8'h20 && c <= 8'h7E) begin
                    wq.push_back('{col: m_col, row: phys(), dat: c});
                    if (m_col < COLS - 1) m_col++;
                    else if (AW != 0) begin
                        m_col = 0;
                        line_feed();
                    end
                end else if (c == 8'h07) begin
                    exp_bell = 1;
                    exp_bells++;
                end else if (c == 8'h08) begin
                    if (m_col > 0) m_col--;
                end else if (c == 8'h09) begin
                    nt = (m_col / TABW + 1) * TABW;
                    if (nt <= COLS - 1) m_col = nt;
                    else if (m_col < COLS - 1) m_col++;
                end else if (c == 8'h0A) line_feed();
                else if (c == 8'h0D) m_col = 0;
                else if (c == 8'h1B) m_mode = 1;
            end
            1: begin
                m_mode = 0;
                case (c)
                    8'h41: if (m_lrow > 0) m_lrow--;
                    8'h42: if (m_lrow < ROWS - 1) m_lrow++;
                    8'h43: if (m_col < COLS - 1) m_col++;
                    8'h44: if (m_col > 0) m_col--;
                    8'h48: begin m_col = 0; m_lrow = 0; end
                    8'h49: begin
                        if (m_lrow == 0) begin
                            m_top = (m_top + ROWS - 1) % ROWS;
                            push_clear(0, m_top, COLS);
                        end else m_lrow--;
                    end
                    8'h4A: push_clear(m_col, phys(), (ROWS - 1 - m_lrow) * COLS + COLS - m_col);
                    8'h4B: push_clear(m_col, phys(), COLS - m_col);
                    8'h59: m_mode = 2;
                    8'h5A: begin rq.push_back(8'h1B); rq.push_back(8'h2F); rq.push_back(8'h4B); end
                    default: ;
                endcase
            end
            2: begin
                if (c >= 8'h20 && c - 8'h20 < ROWS) m_lrow = c - 8'h20;
                m_mode = 3;
            end
            default: begin
                if (c >= 8'h20) m_col = (c - 8'h20 > COLS - 1) ? COLS - 1 : c - 8'h20;
                m_mode = 0;
            end
        endcase
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rep_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            rp_pend = 0;
        end else begin
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write: got unexpected (r%0d,c%0d,0x%0h) expected no write", mem_row, mem_col, mem_wdata);
                end else begin
                    e = wq.pop_front();
                    if (int'(mem_col) != e.col || int'(mem_row) != e.row || int'(mem_wdata) != e.dat) begin
                        errors++;
                        $display("FAIL write: got (r%0d,c%0d,0x%0h) expected (r%0d,c%0d,0x%0h) at %0t",
                                 mem_row, mem_col, mem_wdata, e.row, e.col, e.dat, $time);
                    end
                end
            end
            if (bell) seen_bells++;
            if (rp_pend) chk("rep_hold", {25'd0, rep_valid, rep_data}, {25'd0, 1'b1, rp_dat[6:0]});
            if (rep_valid && rep_ready) begin
                if (rq.size() == 0) chk("rep_unexpected", 1, 0);
                else chk("rep_data", rep_data, rq.pop_front());
            end
            rp_pend = rep_valid && !rep_ready;
            rp_dat  = rep_data;
        end
    end

    task automatic send(input int c);
        int n = 0;
        @(negedge clk);
        in_data  = 7'(c);
        in_valid = 1'b1;
        while (!in_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        model_step(c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("cur_col", cur_col, m_col);
        chk("cur_row", cur_row, phys());
        chk("topline", topline, m_top);
        chk("bell", bell, exp_bell);
    endtask

    task automatic low_cycles(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic cad(input int r, input int c);
        send(8'h1B); send(8'h59); send(8'h20 + r); send(8'h20 + c);
    endtask

    task automatic do_reset();
        int n;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        wq.delete();
        rq.delete();
        m_col = 0; m_lrow = 0; m_top = 0; m_mode = 0;
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rep_valid", rep_valid, 0);
        chk("rst_cursor", {cur_col, cur_row, topline, bell}, 0);
        push_clear(0, 0, ROWS * COLS);
        reset = 1'b0;
        n = 0;
        while (!in_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("reset_clear_len", n, ROWS * COLS + 1);
        chk("reset_clear_done", wq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        do_reset();
        // Autowrap at the last column
        cad(0, 79); send(8'h41); send(8'h42);
        // Scroll after reaching the bottom row
        send(8'h0D); send(8'h1B); send(8'h48);
        for (int i = 0; i < 23; i++) send(8'h0A);
        send(8'h0A); low_cycles(n); chk("scroll_busy", n, COLS);
        // Direct cursor addressing with out-of-range bytes
        send(8'h1B); send(8'h59); send(8'h25); send(8'h7F);
        send(8'h1B); send(8'h59); send(8'h50); send(8'h21);
        // Bring topline to 3, then clear to end of screen from (22,40)
        cad(23, 0); send(8'h0A); low_cycles(n); send(8'h0A); low_cycles(n);
        cad(22, 40); send(8'h1B); send(8'h4A); low_cycles(n); chk("eos_busy", n, 120);
        // Tabs
        cad(0, 5); send(8'h09); cad(0, 78); send(8'h09);
        // Erase to end of line, reverse scroll at top
        cad(3, 30); send(8'h1B); send(8'h4B); low_cycles(n); chk("eol_busy", n, 50);
        send(8'h1B); send(8'h48); send(8'h1B); send(8'h49); low_cycles(n); chk("rlf_busy", n, COLS);
        // Autowrap at the bottom-right corner scrolls after the character write
        cad(23, 79); send(8'h78); low_cycles(n); chk("wrap_scroll_busy", n, COLS + 1);
        send(8'h07);
        // Identify with the reply consumer stalled
        stall_until = cyc + 6;
        send(8'h1B); send(8'h5A);
        @(negedge clk);
        chk("rep_valid_rise", rep_valid, 1);
        chk("rep_first", rep_data, 8'h1B);
        chk("rep_blocks_input", in_ready, 0);
        low_cycles(n);
        chk("rep_drained", rq.size(), 0);
        // Reset in the middle of a full-screen clear
        send(8'h1B); send(8'h48); send(8'h1B); send(8'h4A);
        repeat (50) @(posedge clk);
        do_reset();
        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) send($urandom_range(8'h20, 8'h7F));
            else if (r < 65) begin
                case ($urandom_range(0, 6))
                    0: send(8'h07); 1: send(8'h08); 2: send(8'h09); 3: send(8'h0A);
                    4: send(8'h0D); 5: send(8'h7F); default: send(8'h01);
                endcase
            end else if (r < 85) begin
                send(8'h1B);
                case ($urandom_range(0, 10))
                    0: send(8'h41); 1: send(8'h42); 2: send(8'h43); 3: send(8'h44);
                    4: send(8'h48); 5: send(8'h49); 6: send(8'h4A); 7: send(8'h4B);
                    8: send(8'h5A); 9: send(8'h0D); default: send(8'h51);
                endcase
            end else begin
                send(8'h1B); send(8'h59);
                send($urandom_range(8'h10, 8'h7F)); send($urandom_range(8'h10, 8'h7F));
            end
        end
        low_cycles(n);
        repeat (5) @(negedge clk);
        chk("writes_drained", wq.size(), 0);
        chk("replies_drained", rq.size(), 0);
        chk("bell_pulses", seen_bells, exp_bells);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vt52_term_core.md
# vt52_term_core

Parametrised VT52-style terminal engine: consumes a 7-bit character stream over a valid/ready handshake and maintains a circular screen buffer through a single write port. It exports cursor and scroll state to the video generator, and answers ESC Z identify requests on a reply stream. Compared with the fixed 80x24 engine, it adds:
- Back-pressure, so no characters are dropped while the engine is clearing.
- Configurable geometry.
- Optional autowrap.
- Clear-to-end-of-screen from the cursor.
- Reverse-scroll line clearing.

It sits between the UART receiver and the screen RAM/videogen.

## Interface
Parameters:
- COLS, 80, columns per row (2..127)
- ROWS, 24, rows per screen (2..31)
- CW, 7, column index width (2^CW >= COLS)
- RW, 5, row index width (2^RW >= ROWS)
- TABW, 8, tab stop spacing (power of two)
- AUTOWRAP, 0, 1 = writing the last column advances to column 0 of the next row

Ports (reset: `reset`, asynchronous, active-high; clock: `clk`):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_data  in  7  received character
- in_valid  in  1  in_data valid
- in_ready  out  1  engine accepts in_data this cycle
- mem_we  out  1  screen RAM write strobe
- mem_col  out  CW  write column
- mem_row  out  RW  write physical row
- mem_wdata  out  7  write data (0x00 on clears)
- cur_col  out  CW  cursor column
- cur_row  out  RW  cursor physical row, = (logical row + topline) mod ROWS
- topline  out  RW  physical row shown at screen top
- bell  out  1  one-cycle pulse per BEL
- rep_data  out  7  reply character
- rep_valid  out  1  reply valid
- rep_ready  in  1  reply consumer ready

## Operation
- **Transfer rule.** A character transfers on in_valid & in_ready.
- **States.** IDLE, ESC, CADY, CADX, CLEAR, REPLY.
- **in_ready.** High only in IDLE, ESC, CADY and CADX.
- **Printable characters (0x20–0x7E) in IDLE.**
  - The character is written at the cursor (logical col, physical row).
  - If col < COLS-1, col+1.
  - Else, with AUTOWRAP=0, col holds.
  - Else, with AUTOWRAP=1, col becomes 0 and a LF is performed.
- **0x7F** is ignored.
- **Controls in IDLE.**
  - BEL(0x07) pulses bell.
  - BS(0x08): col-1, saturating at 0.
  - HT(0x09): to the next multiple of TABW if that is <= COLS-1, else col+1, saturating at COLS-1.
  - LF(0x0A): row+1; at logical row ROWS-1 it scrolls instead.
  - CR(0x0D): col 0.
  - ESC(0x1B): go to ESC.
  - Other controls are ignored.
- **Scroll (LF at bottom).** topline = (topline+1) mod ROWS, then CLEAR the new bottom row, COLS cells.
- **ESC state.** Any next character is consumed and the engine returns to IDLE unless noted:
  - 'A' up, saturating.
  - 'B' down, saturating.
  - 'C' right, saturating.
  - 'D' left, saturating.
  - 'H' home.
  - 'I' reverse LF: at logical row 0, topline = (topline-1) mod ROWS and CLEAR the new top row.
  - 'J' CLEAR from the cursor to the end of the screen.
  - 'K' CLEAR from the cursor to the end of the line.
  - 'Y' goes to CADY.
  - 'Z' goes to REPLY.
  - Anything else is ignored.
- **CADY.** With r = in_data-0x20: if in_data >= 0x20 and r < ROWS, logical row = r; otherwise the row is unchanged. Go to CADX.
- **CADX.** With c = in_data-0x20: if in_data >= 0x20, col = min(c, COLS-1); otherwise unchanged. Go to IDLE.
- **CLEAR.**
  - Writes 0x00 one cell per cycle, walking columns, then the next physical row (mod ROWS), until the end cell.
  - The cursor does not move.
  - ESC J at col 0, logical row 0 clears ROWS*COLS cells.
- **REPLY.**
  - Emits ESC(0x1B), '/'(0x2F), 'K'(0x4B) in order.
  - Each byte is held until rep_ready.
  - The engine then returns to IDLE.
- **Reset.**
  - Cursor = 0,0; topline = 0; bell = 0; rep_valid = 0; in_ready = 0; mem_we = 0.
  - Then a full-screen CLEAR runs from physical (0,0).
  - in_ready rises the cycle after the last write.

## Timing
- **Printable write.** mem_we is high for exactly one cycle, the cycle after transfer, with the pre-advance cursor position. The cursor update is visible in the same cycle.
- **Printable throughput.** in_ready stays high, so throughput is 1 char/cycle.
- **Clear-inducing transfers** (LF/ESC I scroll, ESC J, ESC K):
  - in_ready drops the cycle after transfer.
  - The first clear write is in the cycle after transfer.
  - A clear of N cells occupies N consecutive mem_we cycles.
  - in_ready returns high the cycle after the last write.
- **Autowrap with scroll.** The character write occurs first, then the COLS clear writes follow back-to-back.
- **Reply handshake.**
  - ESC Z: rep_valid rises the cycle after transfer.
  - The next byte is presented the cycle after each rep_valid & rep_ready.
  - in_ready returns the cycle after the 'K' handshake.
- **Outputs are registered.** topline and cur_row change the cycle after transfer, before any clear writes.
- **Reset mid-clear or mid-reply.** Abandons the operation immediately and restarts the reset clear.

## Test plan
- **Reset clear.** Release reset with COLS=80, ROWS=24: exactly 1920 mem_we cycles of 0x00, covering every (row, col) once; then in_ready=1, cursor 0,0.
- **Autowrap.** Send "AB" to a cursor at col 79 (AUTOWRAP=1): 'A' written at (0,79), 'B' at (1,0). With AUTOWRAP=0, 'B' overwrites (0,79).
- **Scroll.** 23 LFs from row 0, then one more LF: topline 0->1; 80 zero writes to physical row 0; in_ready low for 80 cycles; cur_row = 0.
- **Direct cursor address.** ESC Y 0x25 0x7F: logical row 5, col 79. ESC Y 0x50 0x21: row unchanged, col 1.
- **Clear to end of screen and tab.** ESC J at logical (22,40) with topline 3: 40+80 writes, covering physical row 1 cols 40–79 then physical row 2; in_valid held high is not accepted meanwhile. HT from col 5 goes to col 8; HT at col 78 goes to col 79.
- **Identify.** ESC Z with rep_ready low for 3 cycles: 0x1B held stable, then 0x2F, then 0x4B; no input accepted until the final handshake.
